// File: rtl/sys_conv_array_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sys_conv_array_if                                            |
// | Description : Kernel-load, window and result streams of sys_conv_array.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface sys_conv_array_if #(
    parameter int K      = 3,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
);
    logic                    kern_we;
    logic [K*K*DATA_W-1:0]   kern_in;
    logic                    kern_ready;
    logic                    in_valid;
    logic                    in_ready;
    logic [K*K*DATA_W-1:0]   data_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [ACC_W-1:0]        result;
    logic [15:0]             res_count;

    modport master (
        output kern_we, kern_in, in_valid, data_in, out_ready,
        input  kern_ready, in_ready, out_valid, result, res_count
    );

    modport slave (
        input  kern_we, kern_in, in_valid, data_in, out_ready,
        output kern_ready, in_ready, out_valid, result, res_count
    );
endinterface
`default_nettype wire

// File: rtl/sys_conv_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sys_conv_array                                               |
// | Description : Pipelined KxK signed dot product with a registered adder     |
// |               tree, valid/ready backpressure and run-time kernel load.     |
// |               Define SYS_CONV_RELU_EN to clamp negative results to zero.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module sys_conv_array #(
    parameter int K      = 3,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  wire logic        clk,
    input  wire logic        reset,
    sys_conv_array_if.slave  bus
);
    localparam int TAPS = K * K;
    localparam int LVLS = $clog2(TAPS);
    localparam int LAT  = 1 + LVLS;

    function automatic int lvl_n(input int l);
        int n = TAPS;
        for (int j = 0; j < l; j++) n = (n + 1) / 2;
        return n;
    endfunction

    // Offset of level l inside the flat node array (level 0 = products).
    function automatic int lvl_off(input int l);
        int o = 0;
        for (int j = 0; j < l; j++) o = o + lvl_n(j);
        return o;
    endfunction

    localparam int NODES = lvl_off(LVLS + 1);

    function automatic logic [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
        return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    logic [DATA_W-1:0] r_kern [TAPS];
    logic [ACC_W-1:0]  w_prod [TAPS];
    logic [ACC_W-1:0]  r_node [NODES];
    logic [LAT-1:0]    r_vld;
    logic              r_out_valid;
    logic [ACC_W-1:0]  r_result;
    logic [15:0]       r_res_count;
    logic              r_up;
    logic              w_stall;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_kern_ready;
    logic [ACC_W-1:0]  w_sum;
    logic [ACC_W-1:0]  w_final;

    assign w_stall      = r_out_valid && !bus.out_ready;
    assign w_in_ready   = r_up && !w_stall;
    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_kern_ready = r_up && (r_vld == '0) && !r_out_valid && !bus.in_valid;

    // Both operands widened to ACC_W: the low ACC_W bits equal the exact signed product.
    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            w_prod[i] = sext(bus.data_in[(TAPS-1-i)*DATA_W +: DATA_W]) * sext(r_kern[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) r_kern[i] <= '0;
        end else if (bus.kern_we && w_kern_ready) begin
            for (int i = 0; i < TAPS; i++) r_kern[i] <= bus.kern_in[(TAPS-1-i)*DATA_W +: DATA_W];
        end
    end

    for (genvar i = 0; i < TAPS; i++) begin : g_prod
        always_ff @(posedge clk) begin
            if (!w_stall) r_node[i] <= w_prod[i];
        end
    end

    for (genvar l = 1; l <= LVLS; l++) begin : g_lvl
        localparam int N    = lvl_n(l);
        localparam int NP   = lvl_n(l - 1);
        localparam int OFF  = lvl_off(l);
        localparam int POFF = lvl_off(l - 1);
        for (genvar i = 0; i < N; i++) begin : g_node
            if (2*i + 1 < NP) begin : g_add
                always_ff @(posedge clk) begin
                    if (!w_stall) r_node[OFF+i] <= r_node[POFF+2*i] + r_node[POFF+2*i+1];
                end
            end else begin : g_pass
                always_ff @(posedge clk) begin
                    if (!w_stall) r_node[OFF+i] <= r_node[POFF+2*i];
                end
            end
        end
    end

    assign w_sum = r_node[NODES-1];

`ifdef SYS_CONV_RELU_EN
    assign w_final = w_sum[ACC_W-1] ? '0 : w_sum;
`else
    assign w_final = w_sum;
`endif

    // Data registers carry no reset; the valid chain alone decides what is live.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vld       <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_res_count <= '0;
            r_up        <= 1'b0;
        end else begin
            r_up <= 1'b1;
            if (!w_stall) begin
                r_vld       <= {r_vld[LAT-2:0], w_accept};
                r_out_valid <= r_vld[LAT-1];
                if (r_vld[LAT-1]) r_result <= w_final;
            end
            if (r_out_valid && bus.out_ready) r_res_count <= r_res_count + 16'd1;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.kern_ready = w_kern_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.result     = r_result;
    assign bus.res_count  = r_res_count;
endmodule
`default_nettype wire

// File: tb/tb_sys_conv_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sys_conv_array                                            |
// | Description : Scoreboard bench for sys_conv_array (K=3, 16-bit, 32-bit).   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_sys_conv_array;
    localparam int K      = 3;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int TAPS   = K * K;
    localparam int W      = TAPS * DATA_W;

    logic clk = 1'b0;
    logic reset;

    sys_conv_array_if #(.K(K), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    sys_conv_array #(.K(K), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int               errors = 0;
    int               checks = 0;
    int               cyc    = 0;
    logic [ACC_W-1:0] exp_q [$];
    int               pop_cyc [$];
    bit               bp_en  = 1'b0;
    bit               st_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    function automatic logic [W-1:0] pack(input int e [TAPS]);
        logic [W-1:0] v = '0;
        for (int i = 0; i < TAPS; i++) v[(TAPS-1-i)*DATA_W +: DATA_W] = e[i][DATA_W-1:0];
        return v;
    endfunction

    function automatic logic [W-1:0] splat(input int x);
        int e [TAPS];
        for (int i = 0; i < TAPS; i++) e[i] = x;
        return pack(e);
    endfunction

    // Sink ready: held high, or cycling 1-0-1-1-0 during the backpressure phase.
    initial begin
        bit pat [5];
        int k = 0;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bp_en) begin
                bus.out_ready = pat[k % 5];
                k++;
            end else begin
                bus.out_ready = 1'b1;
            end
        end
    end

    // Monitor: pops an expectation for every result the sink accepts.
    initial begin
        logic [ACC_W-1:0] hold_res = '0;
        logic [ACC_W-1:0] e;
        bit               was_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (st_chk) begin
                chk(bus.in_ready == !(bus.out_valid && !bus.out_ready), "in_ready_vs_stall",
                    32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
                if (was_stall)
                    chk(bus.out_valid && bus.result == hold_res, "stall_hold", bus.result, hold_res);
            end
            was_stall = bus.out_valid && !bus.out_ready;
            hold_res  = bus.result;
            if (bus.out_valid && bus.out_ready) begin
                pop_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_result", bus.result, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk(bus.result === e, "result", bus.result, e);
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic [ACC_W-1:0] e, output int acc_cyc);
        int t = 0;
        acc_cyc = 0;
        bus.in_valid = 1'b1;
        bus.data_in  = d;
        @(negedge clk);
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            chk(1'b0, "in_ready_timeout", 32'(bus.in_ready), 32'h1);
            bus.in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic load_kernel(input logic [W-1:0] k);
        int t = 0;
        bus.kern_we = 1'b1;
        bus.kern_in = k;
        @(negedge clk);
        while (!bus.kern_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.kern_ready) chk(1'b0, "kern_ready_timeout", 32'(bus.kern_ready), 32'h1);
        @(posedge clk); #1;
        bus.kern_we = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || bus.out_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0 || bus.out_valid)
            chk(1'b0, "drain_timeout", 32'(exp_q.size()), 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int               kb [TAPS];
        int               seq [TAPS];
        int               acc;
        int               t;
        bit               busy;
        logic [ACC_W-1:0] basic_exp;

        reset        = 1'b0;
        bus.kern_we  = 1'b0;
        bus.kern_in  = '0;
        bus.in_valid = 1'b0;
        bus.data_in  = '0;
        kb  = '{1, 0, -1, 1, 0, -1, 1, 0, -1};
        seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9};

        // Reset state and ready release
        repeat (2) @(posedge clk);
        #1;
        chk(bus.out_valid == 1'b0, "rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk(bus.result == '0, "rst_result", bus.result, 32'h0);
        chk(bus.res_count == 16'h0, "rst_res_count", 32'(bus.res_count), 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk(bus.in_ready == 1'b1, "in_ready_after_rst", 32'(bus.in_ready), 32'h1);
        chk(bus.kern_ready == 1'b1, "kern_ready_after_rst", 32'(bus.kern_ready), 32'h1);

        // Basic dot product and latency
`ifdef SYS_CONV_RELU_EN
        basic_exp = 32'h0000_0000;
`else
        basic_exp = 32'hFFFF_FFFA;
`endif
        load_kernel(pack(kb));
        send(pack(seq), basic_exp, acc);
        repeat (4) @(posedge clk);
        #1;
        chk(bus.out_valid == 1'b0, "latency_early", 32'(bus.out_valid), 32'h0);
        @(posedge clk); #1;
        chk(bus.out_valid == 1'b1, "latency_5", 32'(bus.out_valid), 32'h1);
        wait_drain();

        // Streaming, no backpressure
        do_reset();
        load_kernel(splat(1));
        pop_cyc.delete();
        for (int n = 1; n <= 10; n++) send(splat(n), 32'(9 * n), acc);
        wait_drain();
        chk(pop_cyc.size() == 10, "stream_count", 32'(pop_cyc.size()), 32'd10);
        if (pop_cyc.size() == 10)
            chk(pop_cyc[9] - pop_cyc[0] == 9, "stream_no_bubbles", 32'(pop_cyc[9] - pop_cyc[0]), 32'd9);
        chk(bus.res_count == 16'd10, "res_count_10", 32'(bus.res_count), 32'd10);

        // Backpressure
        pop_cyc.delete();
        st_chk = 1'b1;
        bp_en  = 1'b1;
        for (int n = 1; n <= 10; n++) send(splat(n), 32'(9 * n), acc);
        wait_drain();
        bp_en  = 1'b0;
        st_chk = 1'b0;
        chk(pop_cyc.size() == 10, "bp_count", 32'(pop_cyc.size()), 32'd10);
        chk(bus.res_count == 16'd20, "res_count_20", 32'(bus.res_count), 32'd20);

        // Kernel reload while windows are in flight
        for (int n = 1; n <= 3; n++) send(splat(n), 32'(9 * n), acc);
        bus.kern_we = 1'b1;
        bus.kern_in = splat(2);
        t = 0;
        do begin
            @(negedge clk);
            busy = (exp_q.size() != 0) || bus.out_valid;
            chk(bus.kern_ready == !busy, "kern_ready_vs_busy", 32'(bus.kern_ready), 32'(!busy));
            t++;
        end while (!bus.kern_ready && t < 50);
        @(posedge clk); #1;
        bus.kern_we = 1'b0;
        send(pack(seq), 32'd90, acc);
        wait_drain();

        // Window wins over a simultaneous kernel write
        bus.kern_we  = 1'b1;
        bus.kern_in  = splat(1);
        bus.in_valid = 1'b1;
        bus.data_in  = splat(1);
        @(negedge clk);
        chk(bus.kern_ready == 1'b0, "prio_kern_ready", 32'(bus.kern_ready), 32'h0);
        chk(bus.in_ready == 1'b1, "prio_in_ready", 32'(bus.in_ready), 32'h1);
        exp_q.push_back(32'd18);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        load_kernel(splat(1));
        send(pack(seq), 32'd45, acc);
        wait_drain();

        // Extremes: wraps modulo 2^32
        load_kernel(splat(-32768));
        send(splat(-32768), 32'h4000_0000, acc);
        wait_drain();

        // Reset with windows in flight
        for (int n = 1; n <= 3; n++) send(splat(n), 32'h0, acc);
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        chk(bus.out_valid == 1'b0, "midrst_out_valid", 32'(bus.out_valid), 32'h0);
        chk(bus.res_count == 16'h0, "midrst_res_count", 32'(bus.res_count), 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        pop_cyc.delete();
        repeat (10) @(posedge clk);
        #1;
        chk(pop_cyc.size() == 0, "no_stale_result", 32'(pop_cyc.size()), 32'h0);
        send(pack(seq), 32'h0, acc);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
